// File: rtl/i2s_sample_bridge_if.sv
// Stereo sample stream: one left/right pair per valid/ready transfer.
interface i2s_sample_bridge_if #(
  parameter int D_WIDTH = 24
) ();
  logic               valid;
  logic               ready;
  logic [D_WIDTH-1:0] l;
  logic [D_WIDTH-1:0] r;

  modport master (output valid, output l, output r, input  ready);
  modport slave  (input  valid, input  l, input  r, output ready);
endinterface

// File: rtl/i2s_sample_bridge.sv
// i2s_sample_bridge: mclk-domain adapter between the I2S transceiver and the
// effect chain. Captures RX pairs on frame end into a FIFO (stream m) and
// commits TX pairs from stream s to the transceiver once per frame.
// Optional build macro: BRIDGE_MUTE_ON_UNDERRUN_EN (zero outputs on underrun
// instead of repeating the last pair).
module i2s_sample_bridge #(
  parameter int D_WIDTH    = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               mclk,
  input  logic               reset_n,
  input  logic               ws,
  input  logic [D_WIDTH-1:0] l_data_rx,
  input  logic [D_WIDTH-1:0] r_data_rx,
  output logic [D_WIDTH-1:0] l_data_tx,
  output logic [D_WIDTH-1:0] r_data_tx,
  i2s_sample_bridge_if.master m,
  i2s_sample_bridge_if.slave  s,
  output logic [7:0]         ovf_cnt,
  output logic [7:0]         udr_cnt
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PAIR_W = 2 * D_WIDTH;

  typedef enum logic {
    ST_WAIT_RISE,
    ST_ARMED
  } arm_state_e;

  logic                ws_q, ws_d;
  arm_state_e          state_q, state_d;
  logic                push_stb_q, push_stb_d;
  logic                commit_stb_q, commit_stb_d;
  logic [PAIR_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PAIR_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [7:0]          ovf_cnt_q, ovf_cnt_d;
  logic [7:0]          udr_cnt_q, udr_cnt_d;
  logic [PAIR_W-1:0]   pend_q, pend_d;
  logic                pend_full_q, pend_full_d;
  logic [D_WIDTH-1:0]  tx_l_q, tx_l_d;
  logic [D_WIDTH-1:0]  tx_r_q, tx_r_d;

  logic rise, fall, pop, push_ok, xfer;

  // Edge detect on ws, arming FSM, and one-cycle-delayed frame strobes
  always_comb begin
    ws_d         = ws;
    state_d      = state_q;
    rise         = ws & ~ws_q;
    fall         = ~ws & ws_q;
    push_stb_d   = fall & (state_q == ST_ARMED);
    commit_stb_d = rise & (state_q == ST_ARMED);
    if (state_q == ST_WAIT_RISE && rise) begin
      state_d = ST_ARMED;
    end
  end

  // RX FIFO: push on frame strobe (pop in the same cycle frees a slot)
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_cnt_d = ovf_cnt_q;
    pop       = (count_q != '0) & m.ready;
    push_ok   = push_stb_q & ((count_q != CNT_W'(FIFO_DEPTH)) | pop);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = {l_data_rx, r_data_rx};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else if (push_stb_q && ovf_cnt_q != 8'hFF) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  // TX path: pending register loaded from stream s, committed on frame rise
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    tx_l_d      = tx_l_q;
    tx_r_d      = tx_r_q;
    udr_cnt_d   = udr_cnt_q;
    xfer        = s.valid & reset_n & ~pend_full_q;
    if (commit_stb_q) begin
      if (pend_full_q) begin
        tx_l_d      = pend_q[PAIR_W-1:D_WIDTH];
        tx_r_d      = pend_q[D_WIDTH-1:0];
        pend_full_d = 1'b0;
      end else begin
        if (udr_cnt_q != 8'hFF) begin
          udr_cnt_d = udr_cnt_q + 8'd1;
        end
`ifdef BRIDGE_MUTE_ON_UNDERRUN_EN
        tx_l_d = '0;
        tx_r_d = '0;
`else
        tx_l_d = tx_l_q;
        tx_r_d = tx_r_q;
`endif
      end
    end
    // A transfer implies the old pend_full was 0, so any same-cycle commit was
    // an underrun and the new pair waits for the next frame.
    if (xfer) begin
      pend_d      = {s.l, s.r};
      pend_full_d = 1'b1;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      ws_q         <= 1'b0;
      state_q      <= ST_WAIT_RISE;
      push_stb_q   <= 1'b0;
      commit_stb_q <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_cnt_q    <= '0;
      udr_cnt_q    <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      tx_l_q       <= '0;
      tx_r_q       <= '0;
    end else begin
      ws_q         <= ws_d;
      state_q      <= state_d;
      push_stb_q   <= push_stb_d;
      commit_stb_q <= commit_stb_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_cnt_q    <= ovf_cnt_d;
      udr_cnt_q    <= udr_cnt_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      tx_l_q       <= tx_l_d;
      tx_r_q       <= tx_r_d;
    end
  end

  // Output drive
  always_comb begin
    m.valid   = (count_q != '0);
    m.l       = mem_q[rd_ptr_q][PAIR_W-1:D_WIDTH];
    m.r       = mem_q[rd_ptr_q][D_WIDTH-1:0];
    s.ready   = reset_n & ~pend_full_q;
    l_data_tx = tx_l_q;
    r_data_tx = tx_r_q;
    ovf_cnt   = ovf_cnt_q;
    udr_cnt   = udr_cnt_q;
  end

endmodule

// File: tb/tb_i2s_sample_bridge.sv
// Randomized + directed bench for i2s_sample_bridge against a queue-based
// frame-level reference model.
module tb_i2s_sample_bridge;
  localparam int DW    = 24;
  localparam int DEPTH = 4;

  logic          mclk = 1'b0;
  logic          reset_n;
  logic          ws;
  logic [DW-1:0] l_rx, r_rx, l_tx, r_tx;
  logic [7:0]    ovf_cnt, udr_cnt;

  i2s_sample_bridge_if #(.D_WIDTH(DW)) m_if ();
  i2s_sample_bridge_if #(.D_WIDTH(DW)) s_if ();

  i2s_sample_bridge #(.D_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .mclk      (mclk),
    .reset_n   (reset_n),
    .ws        (ws),
    .l_data_rx (l_rx),
    .r_data_rx (r_rx),
    .l_data_tx (l_tx),
    .r_data_tx (r_tx),
    .m         (m_if.master),
    .s         (s_if.slave),
    .ovf_cnt   (ovf_cnt),
    .udr_cnt   (udr_cnt)
  );

  always #5 mclk = ~mclk;

  int total = 0;
  int bad   = 0;

  task automatic check_value(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, frame events take effect one edge late
  logic [47:0]   mq[$];
  bit            md_armed, md_ws_prev, md_push_due, md_commit_due, md_pend_full;
  logic [47:0]   md_pend;
  logic [DW-1:0] md_tx_l, md_tx_r;
  int            md_ovf, md_udr;

  function void model_edge();
    bit pop, xfer, rise, fall;
    if (!reset_n) begin
      mq.delete();
      md_armed = 0; md_ws_prev = 0; md_push_due = 0; md_commit_due = 0;
      md_pend_full = 0; md_pend = '0; md_tx_l = '0; md_tx_r = '0;
      md_ovf = 0; md_udr = 0;
      return;
    end
    pop  = (mq.size() != 0) && m_if.ready;
    xfer = s_if.valid && !md_pend_full;
    if (pop) void'(mq.pop_front());
    if (md_push_due) begin
      if (mq.size() < DEPTH) mq.push_back({l_rx, r_rx});
      else if (md_ovf < 255) md_ovf++;
    end
    if (md_commit_due) begin
      if (md_pend_full) begin
        md_tx_l = md_pend[47:24];
        md_tx_r = md_pend[23:0];
        md_pend_full = 0;
      end else begin
        if (md_udr < 255) md_udr++;
`ifdef BRIDGE_MUTE_ON_UNDERRUN_EN
        md_tx_l = '0;
        md_tx_r = '0;
`endif
      end
    end
    if (xfer) begin
      md_pend = {s_if.l, s_if.r};
      md_pend_full = 1;
    end
    rise = ws && !md_ws_prev;
    fall = !ws && md_ws_prev;
    md_push_due   = fall && md_armed;
    md_commit_due = rise && md_armed;
    if (rise) md_armed = 1;
    md_ws_prev = ws;
  endfunction

  // One clock: advance model, let the edge happen, compare all outputs
  task automatic tick();
    model_edge();
    @(posedge mclk);
    #1;
    check_value("m_valid", {47'b0, m_if.valid}, {47'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      check_value("m_l", {24'b0, m_if.l}, {24'b0, mq[0][47:24]});
      check_value("m_r", {24'b0, m_if.r}, {24'b0, mq[0][23:0]});
    end
    check_value("s_ready", {47'b0, s_if.ready}, {47'b0, reset_n && !md_pend_full});
    check_value("l_tx", {24'b0, l_tx}, {24'b0, md_tx_l});
    check_value("r_tx", {24'b0, r_tx}, {24'b0, md_tx_r});
    check_value("ovf_cnt", {40'b0, ovf_cnt}, 48'(md_ovf));
    check_value("udr_cnt", {40'b0, udr_cnt}, 48'(md_udr));
  endtask

  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int hl);
    ws = 1'b1;
    repeat (hl) tick();
    ws = 1'b0; l_rx = l; r_rx = r;
    repeat (hl) tick();
  endtask

  task automatic rand_tick();
    m_if.ready = 1'($urandom_range(0, 1));
    s_if.valid = ($urandom_range(0, 9) < 3);
    s_if.l = DW'($urandom);
    s_if.r = DW'($urandom);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; ws = 1'b0; l_rx = '0; r_rx = '0;
    m_if.ready = 1'b0; s_if.valid = 1'b0; s_if.l = '0; s_if.r = '0;

    // Reset state
    repeat (3) tick();
    check_value("rst_s_ready", {47'b0, s_if.ready}, 48'd0);
    check_value("rst_m_valid", {47'b0, m_if.valid}, 48'd0);
    reset_n = 1'b1;
    tick();
    check_value("rel_s_ready", {47'b0, s_if.ready}, 48'd1);
    check_value("rel_tx", {l_tx, r_tx}, 48'd0);

    // Arming: first rise arms without committing; next fall captures
    ws = 1'b1;
    repeat (4) tick();
    check_value("arm_udr", {40'b0, udr_cnt}, 48'd0);
    check_value("arm_novalid", {47'b0, m_if.valid}, 48'd0);
    ws = 1'b0; l_rx = 24'h123456; r_rx = 24'hABCDEF;
    tick();
    check_value("arm_valid_1", {47'b0, m_if.valid}, 48'd0);
    tick();
    check_value("arm_valid_2", {47'b0, m_if.valid}, 48'd1);
    check_value("arm_pair", {m_if.l, m_if.r}, 48'h123456ABCDEF);
    m_if.ready = 1'b1;
    repeat (2) tick();

    // Overflow: six frames into a four-entry FIFO with no reader
    m_if.ready = 1'b0;
    for (int i = 0; i < 6; i++) frame(DW'(i + 1), DW'(24'hF00000 + i), 3);
    check_value("ovf_two", {40'b0, ovf_cnt}, 48'd2);
    m_if.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_value("ovf_order", {24'b0, m_if.l}, 48'(k + 1));
      tick();
    end
    check_value("ovf_drained", {47'b0, m_if.valid}, 48'd0);

    // Simultaneous pop and push on a full FIFO
    m_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) frame(DW'(24'h100 + i), DW'(i), 3);
    ws = 1'b1;
    repeat (3) tick();
    ws = 1'b0; l_rx = 24'h00BEEF; r_rx = 24'h00CAFE;
    tick();
    m_if.ready = 1'b1;
    tick();
    m_if.ready = 1'b0;
    check_value("pp_ovf", {40'b0, ovf_cnt}, 48'd2);
    check_value("pp_head", {24'b0, m_if.l}, 48'h101);
    repeat (2) tick();
    m_if.ready = 1'b1;
    repeat (3) tick();
    check_value("pp_new_tail", {m_if.l, m_if.r}, 48'h00BEEF00CAFE);
    tick();
    m_if.ready = 1'b0;

    // TX commit two edges after the rise
    s_if.valid = 1'b1; s_if.l = 24'h000111; s_if.r = 24'h000222;
    tick();
    s_if.valid = 1'b0;
    check_value("tx_busy", {47'b0, s_if.ready}, 48'd0);
    ws = 1'b1;
    tick();
    check_value("tx_not_yet", {47'b0, s_if.ready}, 48'd0);
    tick();
    check_value("tx_commit", {l_tx, r_tx}, 48'h000111000222);
    check_value("tx_ready_back", {47'b0, s_if.ready}, 48'd1);
    ws = 1'b0;
    repeat (3) tick();

    // Underrun accounting and saturation
    for (int i = 0; i < 300; i++) frame(24'h0, 24'h0, 2);
    check_value("udr_sat", {40'b0, udr_cnt}, 48'd255);
`ifdef BRIDGE_MUTE_ON_UNDERRUN_EN
    check_value("udr_out", {l_tx, r_tx}, 48'd0);
`else
    check_value("udr_out", {l_tx, r_tx}, 48'h000111000222);
`endif

    // Mid-frame reset with three queued pairs and a pending TX pair
    m_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) frame(DW'(24'h500 + i), DW'(i), 3);
    s_if.valid = 1'b1; s_if.l = 24'h777777; s_if.r = 24'h888888;
    tick();
    s_if.valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_value("mr_valid", {47'b0, m_if.valid}, 48'd0);
    check_value("mr_tx", {l_tx, r_tx}, 48'd0);
    check_value("mr_cnts", {32'b0, ovf_cnt, udr_cnt}, 48'd0);
    repeat (2) tick();
    ws = 1'b1;
    repeat (3) tick();
    check_value("mr_rearm_udr", {40'b0, udr_cnt}, 48'd0);
    ws = 1'b0; l_rx = 24'h00AAAA; r_rx = 24'h00BBBB;
    repeat (2) tick();
    check_value("mr_capture", {m_if.l, m_if.r}, 48'h00AAAA00BBBB);

    // Randomized traffic against the model
    for (int f = 0; f < 250; f++) begin
      ws = 1'b1;
      repeat ($urandom_range(2, 8)) rand_tick();
      ws = 1'b0; l_rx = DW'($urandom); r_rx = DW'($urandom);
      repeat ($urandom_range(2, 8)) rand_tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
